// File: rtl/uart_dbg_bridge.sv
// Debug-protocol responder between the uart byte interface and a req/ack memory bus.
// Decodes 'R'/'W' commands, runs one 32-bit bus transaction and streams the reply.
module uart_dbg_bridge #(
  parameter int unsigned BUS_TIMEOUT = 1024,
  parameter logic [7:0]  OP_READ     = 8'h52,
  parameter logic [7:0]  OP_WRITE    = 8'h57
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_data_fresh,
  output logic [7:0]  tx_data,
  output logic        tx_data_valid,
  input  logic        tx_data_ack,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack,
  output logic        busy
);

  localparam int unsigned     TMO_W    = $clog2(BUS_TIMEOUT);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(BUS_TIMEOUT - 1);
  localparam logic [7:0]      RSP_OK   = 8'h4B;
  localparam logic [7:0]      RSP_BAD  = 8'h3F;
  localparam logic [7:0]      RSP_ERR  = 8'h45;

  typedef enum logic [2:0] {IDLE, ADDR, WDATA, BUS, RESP} state_t;

  state_t           state;
  logic [1:0]       byte_cnt;
  logic [TMO_W-1:0] tmo_cnt;
  logic [31:0]      resp;
  logic [2:0]       resp_cnt;

  // Command decode, bus sequencing and response streaming in one registered FSM.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      byte_cnt      <= '0;
      tmo_cnt       <= '0;
      resp          <= '0;
      resp_cnt      <= '0;
      tx_data       <= '0;
      tx_data_valid <= 1'b0;
      bus_req       <= 1'b0;
      bus_we        <= 1'b0;
      bus_addr      <= '0;
      bus_wdata     <= '0;
      busy          <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (rx_data_fresh) begin
            byte_cnt <= '0;
            busy     <= 1'b1;
            if (rx_data == OP_READ) begin
              bus_we <= 1'b0;
              state  <= ADDR;
            end else if (rx_data == OP_WRITE) begin
              bus_we <= 1'b1;
              state  <= ADDR;
            end else begin
              resp          <= {RSP_BAD, 24'h0};
              resp_cnt      <= 3'd1;
              tx_data       <= RSP_BAD;
              tx_data_valid <= 1'b1;
              state         <= RESP;
            end
          end
        end
        ADDR: begin
          if (rx_data_fresh) begin
            bus_addr <= {bus_addr[23:0], rx_data};
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              if (bus_we) begin
                state <= WDATA;
              end else begin
                state   <= BUS;
                bus_req <= 1'b1;
                tmo_cnt <= '0;
              end
            end
          end
        end
        WDATA: begin
          if (rx_data_fresh) begin
            bus_wdata <= {bus_wdata[23:0], rx_data};
            byte_cnt  <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              state   <= BUS;
              bus_req <= 1'b1;
              tmo_cnt <= '0;
            end
          end
        end
        BUS: begin
          // An ack on the final timeout cycle still completes the transaction.
          if (bus_req && bus_ack) begin
            bus_req       <= 1'b0;
            tx_data_valid <= 1'b1;
            state         <= RESP;
            if (bus_we) begin
              resp     <= {RSP_OK, 24'h0};
              resp_cnt <= 3'd1;
              tx_data  <= RSP_OK;
            end else begin
              resp     <= bus_rdata;
              resp_cnt <= 3'd4;
              tx_data  <= bus_rdata[31:24];
            end
          end else if (tmo_cnt == TMO_LAST) begin
            bus_req       <= 1'b0;
            resp          <= {RSP_ERR, 24'h0};
            resp_cnt      <= 3'd1;
            tx_data       <= RSP_ERR;
            tx_data_valid <= 1'b1;
            state         <= RESP;
          end else begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
          end
        end
        RESP: begin
          // Drop valid for one cycle after each ack, then present the next byte.
          if (tx_data_valid) begin
            if (tx_data_ack) begin
              tx_data_valid <= 1'b0;
              resp          <= {resp[23:0], 8'h00};
              resp_cnt      <= resp_cnt - 3'd1;
              if (resp_cnt == 3'd1) begin
                state <= IDLE;
                busy  <= 1'b0;
              end
            end
          end else begin
            tx_data       <= resp[31:24];
            tx_data_valid <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_dbg_bridge.sv
// Directed bench for uart_dbg_bridge: read, write, bad opcode, timeout,
// transmit backpressure and mid-transaction reset.
module tb_uart_dbg_bridge;

  localparam logic [7:0] OP_R = 8'h52;
  localparam logic [7:0] OP_W = 8'h57;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_data_fresh;
  logic [7:0]  tx_data;
  logic        tx_data_valid;
  logic        tx_data_ack;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_ack;
  logic        busy;

  int errors = 0;
  int checks = 0;

  uart_dbg_bridge #(.BUS_TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .rx_data(rx_data), .rx_data_fresh(rx_data_fresh),
    .tx_data(tx_data), .tx_data_valid(tx_data_valid), .tx_data_ack(tx_data_ack),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_rdata(bus_rdata), .bus_ack(bus_ack), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // All stimulus tasks start and end on a falling edge.
  task automatic send_byte(input logic [7:0] b);
    rx_data = b;
    rx_data_fresh = 1'b1;
    @(negedge clk);
    rx_data_fresh = 1'b0;
  endtask

  task automatic send_cmd(input logic [7:0] op, input logic [31:0] addr);
    send_byte(op);
    for (int i = 3; i >= 0; i--) send_byte(addr[i*8 +: 8]);
  endtask

  // Collect one tx byte; ok clears if it never shows, changes while held, or valid is not dropped after ack.
  task automatic take_byte(input int delay, input bit noise, output logic [7:0] b, output bit ok);
    ok = 1'b0;
    b  = '0;
    for (int i = 0; i < 100; i++) begin
      if (tx_data_valid === 1'b1) break;
      @(negedge clk);
    end
    if (tx_data_valid !== 1'b1) return;
    ok = 1'b1;
    b  = tx_data;
    for (int i = 0; i < delay; i++) begin
      rx_data = OP_W;
      rx_data_fresh = noise;
      @(negedge clk);
      if (tx_data_valid !== 1'b1 || tx_data !== b) ok = 1'b0;
    end
    rx_data_fresh = 1'b0;
    tx_data_ack = 1'b1;
    @(negedge clk);
    tx_data_ack = 1'b0;
    if (tx_data_valid !== 1'b0) ok = 1'b0;
  endtask

  task automatic run_read(input logic [31:0] addr, input logic [31:0] rdata, input int ack_wait,
                          input int delay, input bit noise,
                          output logic [31:0] data, output int req_cycles, output bit ok);
    logic [7:0] b;
    bit bok;
    send_cmd(OP_R, addr);
    req_cycles = 0;
    ok = 1'b1;
    data = '0;
    for (int i = 0; i < ack_wait; i++) begin
      if (bus_req === 1'b1) req_cycles++;
      if (i == ack_wait - 1) begin
        bus_ack = 1'b1;
        bus_rdata = rdata;
      end
      @(negedge clk);
    end
    bus_ack = 1'b0;
    bus_rdata = '0;
    if (bus_req !== 1'b0) ok = 1'b0;
    for (int k = 0; k < 4; k++) begin
      take_byte(delay, noise, b, bok);
      ok = ok & bok;
      data = {data[23:0], b};
    end
  endtask

  task automatic test_reset();
    checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx_data: got %h want 00", tx_data); end
    checks++; if (tx_data_valid !== 1'b0) begin errors++; $display("FAIL reset_tx_valid: got %b want 0", tx_data_valid); end
    checks++; if (bus_req !== 1'b0 || bus_we !== 1'b0) begin errors++; $display("FAIL reset_bus_ctl: got req=%b we=%b want 0 0", bus_req, bus_we); end
    checks++; if (bus_addr !== 32'h0 || bus_wdata !== 32'h0) begin errors++; $display("FAIL reset_bus_data: got addr=%h wdata=%h want 0 0", bus_addr, bus_wdata); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
  endtask

  task automatic test_read();
    logic [31:0] data;
    int rc;
    bit ok;
    run_read(32'h0000_1000, 32'hDEAD_BEEF, 3, 0, 1'b0, data, rc, ok);
    checks++; if (data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL read_data: got %h want deadbeef", data); end
    checks++; if (rc !== 3) begin errors++; $display("FAIL read_req_cycles: got %0d want 3", rc); end
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL read_handshake: got %b want 1", ok); end
    checks++; if (bus_addr !== 32'h0000_1000 || bus_we !== 1'b0) begin errors++; $display("FAIL read_addr: got addr=%h we=%b want 00001000 0", bus_addr, bus_we); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL read_busy_after: got %b want 0", busy); end
  endtask

  task automatic test_write();
    logic [7:0] b;
    bit ok;
    send_cmd(OP_W, 32'h8000_0004);
    send_byte(8'h12); send_byte(8'h34); send_byte(8'h56); send_byte(8'h78);
    checks++; if (bus_req !== 1'b1 || bus_we !== 1'b1) begin errors++; $display("FAIL write_req: got req=%b we=%b want 1 1", bus_req, bus_we); end
    checks++; if (bus_addr !== 32'h8000_0004) begin errors++; $display("FAIL write_addr: got %h want 80000004", bus_addr); end
    checks++; if (bus_wdata !== 32'h1234_5678) begin errors++; $display("FAIL write_wdata: got %h want 12345678", bus_wdata); end
    bus_ack = 1'b1;
    bus_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    bus_ack = 1'b0;
    bus_rdata = '0;
    checks++; if (bus_req !== 1'b0 || tx_data_valid !== 1'b1 || tx_data !== 8'h4B) begin errors++; $display("FAIL write_resp_latency: got req=%b valid=%b data=%h want 0 1 4b", bus_req, tx_data_valid, tx_data); end
    take_byte(0, 1'b0, b, ok);
    checks++; if (ok !== 1'b1 || b !== 8'h4B) begin errors++; $display("FAIL write_resp: got ok=%b byte=%h want 1 4b", ok, b); end
    checks++; if (busy !== 1'b0 || tx_data_valid !== 1'b0) begin errors++; $display("FAIL write_done: got busy=%b valid=%b want 0 0", busy, tx_data_valid); end
  endtask

  task automatic test_bad_opcode();
    logic [7:0] b;
    logic [31:0] data;
    int rc;
    bit ok;
    send_byte(8'h00);
    checks++; if (tx_data_valid !== 1'b1 || tx_data !== 8'h3F) begin errors++; $display("FAIL bad_latency: got valid=%b data=%h want 1 3f", tx_data_valid, tx_data); end
    checks++; if (bus_req !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL bad_noreq: got req=%b busy=%b want 0 1", bus_req, busy); end
    take_byte(0, 1'b0, b, ok);
    checks++; if (ok !== 1'b1 || b !== 8'h3F) begin errors++; $display("FAIL bad_resp: got ok=%b byte=%h want 1 3f", ok, b); end
    run_read(32'h0000_0020, 32'h0102_0304, 2, 0, 1'b0, data, rc, ok);
    checks++; if (data !== 32'h0102_0304 || ok !== 1'b1) begin errors++; $display("FAIL bad_then_read: got data=%h ok=%b want 01020304 1", data, ok); end
  endtask

  task automatic test_timeout();
    logic [7:0] b;
    logic [31:0] data;
    int rc;
    bit ok;
    send_cmd(OP_R, 32'h0000_0040);
    rc = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus_req === 1'b1) rc++;
      @(negedge clk);
    end
    checks++; if (rc !== 8 || bus_req !== 1'b0) begin errors++; $display("FAIL timeout_req_cycles: got %0d req=%b want 8 0", rc, bus_req); end
    take_byte(0, 1'b0, b, ok);
    checks++; if (ok !== 1'b1 || b !== 8'h45) begin errors++; $display("FAIL timeout_resp: got ok=%b byte=%h want 1 45", ok, b); end
    bus_ack = 1'b1;
    bus_rdata = 32'h5555_AAAA;
    @(negedge clk);
    bus_ack = 1'b0;
    bus_rdata = '0;
    @(negedge clk);
    checks++; if (bus_req !== 1'b0 || tx_data_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL late_ack: got req=%b valid=%b busy=%b want 0 0 0", bus_req, tx_data_valid, busy); end
    run_read(32'h0000_0044, 32'hCAFE_F00D, 8, 0, 1'b0, data, rc, ok);
    checks++; if (data !== 32'hCAFE_F00D || rc !== 8 || ok !== 1'b1) begin errors++; $display("FAIL ack_at_timeout: got data=%h cycles=%0d ok=%b want cafef00d 8 1", data, rc, ok); end
  endtask

  task automatic test_backpressure();
    logic [31:0] data;
    int rc;
    bit ok;
    run_read(32'h0000_0100, 32'hA5C3_0F96, 1, 50, 1'b1, data, rc, ok);
    checks++; if (data !== 32'hA5C3_0F96 || ok !== 1'b1) begin errors++; $display("FAIL backpressure: got data=%h ok=%b want a5c30f96 1", data, ok); end
    checks++; if (busy !== 1'b0 || bus_addr !== 32'h0000_0100) begin errors++; $display("FAIL backpressure_idle: got busy=%b addr=%h want 0 00000100", busy, bus_addr); end
    run_read(32'h0000_0104, 32'h1357_9BDF, 1, 0, 1'b0, data, rc, ok);
    checks++; if (data !== 32'h1357_9BDF || ok !== 1'b1) begin errors++; $display("FAIL backpressure_next: got data=%h ok=%b want 13579bdf 1", data, ok); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] data;
    int rc;
    bit ok;
    send_cmd(OP_R, 32'h0000_0200);
    checks++; if (bus_req !== 1'b1) begin errors++; $display("FAIL rst_bus_pre: got req=%b want 1", bus_req); end
    rst = 1'b0;
    #1;
    checks++; if (bus_req !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rst_bus_async: got req=%b busy=%b want 0 0", bus_req, busy); end
    @(negedge clk);
    rst = 1'b1;
    run_read(32'h0000_0204, 32'h2468_ACE0, 2, 0, 1'b0, data, rc, ok);
    checks++; if (data !== 32'h2468_ACE0 || ok !== 1'b1) begin errors++; $display("FAIL rst_bus_next: got data=%h ok=%b want 2468ace0 1", data, ok); end
    send_byte(8'hAA);
    checks++; if (tx_data_valid !== 1'b1) begin errors++; $display("FAIL rst_resp_pre: got valid=%b want 1", tx_data_valid); end
    rst = 1'b0;
    #1;
    checks++; if (tx_data_valid !== 1'b0 || busy !== 1'b0 || tx_data !== 8'h00) begin errors++; $display("FAIL rst_resp_async: got valid=%b busy=%b data=%h want 0 0 00", tx_data_valid, busy, tx_data); end
    @(negedge clk);
    rst = 1'b1;
    run_read(32'h0000_0208, 32'h0F0F_F0F0, 4, 0, 1'b0, data, rc, ok);
    checks++; if (data !== 32'h0F0F_F0F0 || rc !== 4 || ok !== 1'b1) begin errors++; $display("FAIL rst_resp_next: got data=%h cycles=%0d ok=%b want 0f0ff0f0 4 1", data, rc, ok); end
  endtask

  initial begin
    rst = 1'b0;
    rx_data = '0;
    rx_data_fresh = 1'b0;
    tx_data_ack = 1'b0;
    bus_rdata = '0;
    bus_ack = 1'b0;
    repeat (2) @(negedge clk);
    test_reset();
    rst = 1'b1;
    @(negedge clk);
    test_read();
    test_write();
    test_bad_opcode();
    test_timeout();
    test_backpressure();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_dbg_bridge.md
Name: uart_dbg_bridge

Overview:
- Host-side responder on the byte interface of the uart block. It consumes received bytes (rx_data/rx_data_fresh) and produces transmit bytes (tx_data/tx_data_valid/tx_data_ack).
- Decodes a fixed binary debug protocol from a PC and executes single 32-bit read/write transactions on a simple req/ack memory bus.
- Returns the result over the transmit side, giving monitor/loader access to LEG memory and MMIO.

Parameters:
- BUS_TIMEOUT, 1024: cycles bus_req may stay high without bus_ack before the transaction is aborted; minimum 2.
- OP_READ, 8'h52: opcode byte for a read ('R').
- OP_WRITE, 8'h57: opcode byte for a write ('W').

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst  input  1  asynchronous, active-low reset.
- rx_data  input  8  received byte; valid only in the cycle rx_data_fresh=1.
- rx_data_fresh  input  1  one-cycle strobe, a new byte is available.
- tx_data  output  8  byte to transmit.
- tx_data_valid  output  1  tx_data is valid; held until acknowledged.
- tx_data_ack  input  1  one-cycle pulse, the transmitter has captured tx_data.
- bus_req  output  1  bus request.
- bus_we  output  1  1=write, 0=read.
- bus_addr  output  32  word address.
- bus_wdata  output  32  write data.
- bus_rdata  input  32  read data; valid only when bus_ack=1.
- bus_ack  input  1  one-cycle completion strobe.
- busy  output  1  high in every state except IDLE.

Behaviour:
- Reset (rst=0, asynchronous):
  - tx_data=0, tx_data_valid=0, bus_req=0, bus_we=0, bus_addr=0, bus_wdata=0, busy=0.
  - state=IDLE; all counters and shift registers cleared.
  - Reset mid-transaction drops any outstanding bus_req/tx_data_valid immediately. There is no replay.
- Protocol:
  - Read: OP_READ, A3, A2, A1, A0 (address, MSB first). Response: D3, D2, D1, D0 (read data, MSB first).
  - Write: OP_WRITE, A3..A0, D3..D0. Response: 8'h4B ('K').
  - Any other opcode: response 8'h3F ('?'), then return to IDLE.
  - Bus timeout: response 8'h45 ('E').
- States: IDLE, ADDR, WDATA, BUS, RESP.
  - IDLE, on fresh byte:
    - byte==OP_READ -> ADDR with we=0.
    - byte==OP_WRITE -> ADDR with we=1.
    - otherwise -> load '?' as a 1-byte response, go to RESP.
  - ADDR: shift each fresh byte into bus_addr (addr <= {addr[23:0],byte}). On the 4th byte (2-bit counter ==3): go to WDATA if we=1, else BUS.
  - WDATA: same shifting into bus_wdata. On the 4th byte -> BUS.
  - BUS:
    - bus_req=1 from the first BUS cycle. bus_addr, bus_we and bus_wdata are stable while bus_req=1.
    - In the cycle bus_ack=1: capture bus_rdata into the response register; bus_req=0 next cycle; go to RESP. Read loads 4 bytes; write loads 'K' (1 byte).
    - Timeout counter counts cycles with bus_req=1. When it reaches BUS_TIMEOUT-1 with no ack: bus_req=0 next cycle, load 'E', go to RESP.
    - Ack in the same cycle as the timeout: ack wins.
  - RESP:
    - tx_data = MSB byte of the response register; tx_data_valid=1.
    - On tx_data_ack: shift the response register left 8 and decrement the remaining count.
    - tx_data_valid is 0 in the cycle after the ack (minimum 1 idle cycle between bytes), then reasserts with the next byte.
    - After the last byte is acknowledged -> IDLE.
- Handshake rules:
  - tx_data must not change while tx_data_valid=1.
  - tx_data_ack while tx_data_valid=0 is ignored.
  - bus_ack while bus_req=0 is ignored.
- rx_data_fresh while in BUS or RESP: the byte is discarded, with no effect on state.
- Back-to-back fresh bytes (consecutive cycles) in ADDR/WDATA must all be accepted.
- Latency: the first response tx_data_valid is asserted exactly 1 cycle after bus_ack, or 1 cycle after the bad-opcode byte.

Test Plan:
- Read: send 52 00 00 10 00; bus acks after 3 cycles with rdata=DEADBEEF -> bus_addr=00001000, bus_we=0, bus_req high for exactly 3 cycles; tx bytes DE AD BE EF in order; busy low afterwards.
- Write: send 57 80 00 00 04 12 34 56 78; ack after 1 cycle -> bus_we=1, bus_addr=80000004, bus_wdata=12345678; single tx byte 4B.
- Bad opcode: byte 00 -> no bus_req; tx byte 3F; then a valid read completes normally.
- Timeout with BUS_TIMEOUT=8: read with no bus_ack -> bus_req high exactly 8 cycles then low; tx byte 45; a late bus_ack afterwards is ignored.
- Backpressure: delay tx_data_ack by 50 cycles per byte during the read response -> tx_data stable while valid; no byte lost or duplicated; extra rx bytes sent during RESP are ignored.
- Reset mid-BUS and mid-RESP (rst low 1 cycle) -> bus_req, tx_data_valid and busy go low asynchronously; the next command executes correctly.
